serial_adder: RTL
=================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (>=2).
REQ-002 SHALL have parameter DIGIT, default 1, bits added per clock; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  request; operands captured when accepted.
REQ-006 SHALL have port a  input  WIDTH  operand A.
REQ-007 SHALL have port b  input  WIDTH  operand B.
REQ-008 SHALL have port cin  input  1  carry into bit 0.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when sum/cout become valid.
REQ-011 SHALL have port sum  output  WIDTH  result bits, registered.
REQ-012 SHALL have port cout  output  1  carry out of bit WIDTH-1, registered.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 IDLE or DONE with start=1: capture a, b, cin into internal registers, clear digit counter, go to RUN; busy=1 from the next cycle.
REQ-015 IDLE or DONE with start=0: go to / stay in IDLE.
REQ-016 RUN: each cycle add DIGIT bits of A, DIGIT bits of B and the stored carry, LSB digit first, with ripple full-adder logic; store the DIGIT result bits and the new carry.
REQ-017 RUN SHALL last exactly WIDTH/DIGIT cycles, then go to DONE.
REQ-018 DONE: done=1 and busy=0 for exactly one cycle; sum and cout SHALL hold the complete result from that cycle onward.
REQ-019 Latency: first done cycle is WIDTH/DIGIT+1 cycles after the accepting start edge.
REQ-020 start while in RUN SHALL be ignored; captured operands SHALL NOT change.
REQ-021 a, b, cin changing after capture SHALL NOT affect the result.
REQ-022 sum/cout SHALL update only when a result completes and SHALL hold the last result until the next completion; partial results SHALL NOT be visible on sum/cout.
REQ-023 Result SHALL equal (a + b + cin) mod 2^WIDTH, cout = bit WIDTH of the full sum.
REQ-024 start asserted in DONE SHALL begin a new operation back-to-back (no idle cycle).

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE, busy=0, done=0, sum=0, cout=0, counter and carry=0, overriding start.
REQ-026 rst during RUN SHALL abort the operation with no done pulse; the result is discarded.

Configuration
REQ-027 Macro SERIAL_ADDER_SUBTRACT_EN, when defined, SHALL add port sub  input  1, captured with the operands on accepted start.
REQ-028 With the macro defined and sub=1: result SHALL be a + ~b + 1 (cin ignored), cout=1 meaning no borrow; sub=0 behaves as REQ-023.
REQ-029 Without the macro: no sub port, addition only, behaviour exactly as REQ-013 to REQ-026.

Verification
REQ-030 WIDTH=8, DIGIT=1: a=0x0F, b=0x01, cin=0, start pulse -> busy 8 cycles, done at cycle 9, sum=0x10, cout=0.
REQ-031 WIDTH=8, DIGIT=1: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0x80, b=0x80, cin=1 -> sum=0x01, cout=1.
REQ-032 start pulsed mid-RUN with a=0x55, b=0x55 -> ignored; result still that of the first operands; one done pulse.
REQ-033 rst=1 at cycle 4 of RUN -> next cycle busy=0, done=0, sum=0x00, cout=0; no done pulse; a following start completes normally.
REQ-034 WIDTH=8, DIGIT=4: a=0x3C, b=0xC4, cin=0 -> done 3 cycles after start, sum=0x00, cout=1; start held high in DONE -> second result follows with no idle cycle.
REQ-035 SERIAL_ADDER_SUBTRACT_EN defined, WIDTH=8: sub=1, a=0x05, b=0x07 -> sum=0xFE, cout=0; a=0x07, b=0x05 -> sum=0x02, cout=1.

Source files
------------

// File: rtl/serial_adder.sv
// Digit-serial adder: adds DIGIT bits per clock, LSB digit first, result published on done.
// Optional SERIAL_ADDER_SUBTRACT_EN adds a 'sub' input selecting a - b (cout=1 means no borrow).
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_SUBTRACT_EN
  ,
  input  logic             sub
`endif
);

  localparam int unsigned NDIG  = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_nxt;

  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [WIDTH-1:0] res_nxt_c, b_cap_c;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q, carry_nxt_c, cin_cap_c;
  logic [DIGIT-1:0] dsum_c;
  logic [DIGIT:0]   rc_c;
  logic             accept_c, last_c, busy_nxt_c, done_nxt_c;

  assign accept_c = start && (state_q != RUN);
  assign last_c   = (cnt_q == LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE, DONE: state_nxt = accept_c ? RUN : IDLE;
      RUN:        state_nxt = last_c ? DONE : RUN;
      default:    state_nxt = IDLE;
    endcase
  end

  // Output decode from the upcoming state so busy/done come straight off flops
  always_comb begin
    busy_nxt_c = 1'b0;
    done_nxt_c = 1'b0;
    case (state_nxt)
      RUN:     busy_nxt_c = 1'b1;
      DONE:    done_nxt_c = 1'b1;
      default: ;
    endcase
  end

  // Operand conditioning at capture; subtraction folds into a + ~b + 1
  always_comb begin
    b_cap_c   = b;
    cin_cap_c = cin;
`ifdef SERIAL_ADDER_SUBTRACT_EN
    if (sub) begin
      b_cap_c   = ~b;
      cin_cap_c = 1'b1;
    end
`endif
  end

  // One digit of ripple-carry addition; result digits enter the result register at the top
  always_comb begin
    rc_c    = '0;
    dsum_c  = '0;
    rc_c[0] = carry_q;
    for (int i = 0; i < DIGIT; i++) begin
      dsum_c[i]  = a_q[i] ^ b_q[i] ^ rc_c[i];
      rc_c[i+1]  = (a_q[i] & b_q[i]) | (rc_c[i] & (a_q[i] ^ b_q[i]));
    end
    carry_nxt_c = rc_c[DIGIT];
    res_nxt_c   = (res_q >> DIGIT) | (WIDTH'(dsum_c) << (WIDTH - DIGIT));
  end

  // Datapath: capture, shift, and publish on the final digit
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (state_q == RUN) begin
      a_q     <= a_q >> DIGIT;
      b_q     <= b_q >> DIGIT;
      res_q   <= res_nxt_c;
      carry_q <= carry_nxt_c;
      cnt_q   <= cnt_q + CNT_W'(1);
      if (last_c) begin
        sum  <= res_nxt_c;
        cout <= carry_nxt_c;
      end
    end else if (accept_c) begin
      a_q     <= a;
      b_q     <= b_cap_c;
      carry_q <= cin_cap_c;
      cnt_q   <= '0;
    end
  end

  // Registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nxt_c;
      done <= done_nxt_c;
    end
  end

endmodule
